// File: rtl/pixel_stream_feeder.sv
// Feeds raster-ordered frame-buffer pixels to the detector over a level handshake.
// Macro PIXEL_FEEDER_TEST_PATTERN_EN replaces memory reads with a synthetic (x + 16*y) pattern.
module pixel_stream_feeder #(
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 19,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready_recieve_pixel,
  input  logic                  end_frame,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_end_recieve_pixel,
  output logic [11:0]           o_x,
  output logic [11:0]           o_y,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PRESENT,
    RELEASE,
    FRAME_GAP
  } state_t;

  state_t state;
  state_t state_next;
  logic   req_lost;
  logic   gap_seen;
  logic   last_pixel;

`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
  logic [31:0] tp_pix;
  assign tp_pix = 32'(o_x) + (32'(o_y) << 4);
`else
  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);
  logic [2:0] lat_cnt;
`endif

  assign last_pixel = (o_x == 12'(FRAME_WIDTH - 1)) && (o_y == 12'(FRAME_HEIGHT - 1));

  // A request withdrawn mid-fetch keeps the pixel parked until the next request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (ready_recieve_pixel) state_next = FETCH;
`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
      FETCH:     state_next = PRESENT;
`else
      FETCH:     state_next = WAIT;
      WAIT:      if (lat_cnt == LAT_LAST) state_next = PRESENT;
`endif
      PRESENT:   if (!ready_recieve_pixel && !req_lost) state_next = RELEASE;
      RELEASE:   state_next = last_pixel ? FRAME_GAP : IDLE;
      FRAME_GAP: if (gap_seen && !end_frame) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_x        <= '0;
      o_y        <= '0;
      o_mem_addr <= '0;
      o_pixel    <= '0;
      req_lost   <= 1'b0;
      gap_seen   <= 1'b0;
`ifndef PIXEL_FEEDER_TEST_PATTERN_EN
      lat_cnt    <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: req_lost <= 1'b0;
        FETCH: begin
          req_lost <= ~ready_recieve_pixel;
`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
          o_pixel  <= tp_pix[DATA_WIDTH-1:0];
`else
          lat_cnt  <= '0;
`endif
        end
`ifndef PIXEL_FEEDER_TEST_PATTERN_EN
        WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (!ready_recieve_pixel) req_lost <= 1'b1;
          if (lat_cnt == LAT_LAST) o_pixel <= mem_rdata;
        end
`endif
        PRESENT: if (ready_recieve_pixel) req_lost <= 1'b0;
        RELEASE: begin
          gap_seen <= 1'b0;
          if (last_pixel) begin
            o_x        <= '0;
            o_y        <= '0;
            o_mem_addr <= '0;
          end else begin
            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
            if (o_x == 12'(FRAME_WIDTH - 1)) begin
              o_x <= '0;
              o_y <= o_y + 12'd1;
            end else begin
              o_x <= o_x + 12'd1;
            end
          end
        end
        FRAME_GAP: if (end_frame) gap_seen <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
  assign o_mem_rd = 1'b0;
`else
  assign o_mem_rd = (state == FETCH);
`endif
  assign o_end_recieve_pixel = (state == PRESENT) && !req_lost;
  assign o_frame_done        = (state == RELEASE) && last_pixel;
  assign o_busy              = (state != IDLE);

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder on a 4x3 frame; a second instance covers MEM_LATENCY=3.
module tb_pixel_stream_feeder;
  localparam int W = 4, H = 3, N = W * H, DW = 12, AW = 19;
`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif
  localparam int   LAT1   = TP ? 2 : 3;
  localparam int   LAT3   = TP ? 2 : 5;
  localparam logic RD_EXP = !TP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, ready = 1'b0, end_frame = 1'b0;
  logic [DW-1:0] mem [16];

  logic          rd1, end1, done1, busy1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] rdata1, pix1;
  logic [11:0]   x1, y1;
  logic          rd3, end3, done3, busy3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] rdata3, pix3;
  logic [11:0]   x3, y3;

  pixel_stream_feeder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .ready_recieve_pixel(ready), .end_frame(end_frame),
    .o_mem_rd(rd1), .o_mem_addr(addr1), .mem_rdata(rdata1), .o_pixel(pix1),
    .o_end_recieve_pixel(end1), .o_x(x1), .o_y(y1), .o_frame_done(done1), .o_busy(busy1));

  pixel_stream_feeder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .ready_recieve_pixel(ready), .end_frame(end_frame),
    .o_mem_rd(rd3), .o_mem_addr(addr3), .mem_rdata(rdata3), .o_pixel(pix3),
    .o_end_recieve_pixel(end3), .o_x(x3), .o_y(y3), .o_frame_done(done3), .o_busy(busy3));

  // Frame-buffer models: data valid exactly LATENCY cycles after the strobe, garbage otherwise.
  logic          pv1;
  logic [AW-1:0] pa1;
  logic [2:0]    pv3;
  logic [AW-1:0] pa3 [3];
  always @(posedge clk) begin
    pv1    <= rd1;
    pa1    <= addr1;
    pv3    <= {pv3[1:0], rd3};
    pa3[0] <= addr3;
    pa3[1] <= pa3[0];
    pa3[2] <= pa3[1];
  end
  assign rdata1 = pv1    ? mem[pa1[3:0]]    : 12'hF0F;
  assign rdata3 = pv3[2] ? mem[pa3[2][3:0]] : 12'hF0F;

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;
  int idx = 0, rd_total = 0;
  bit prev_end = 1'b0, rd_since = 1'b0, in_gap = 1'b0, gap_hi = 1'b0, addr_over = 1'b0;

  typedef struct {
    int ex;
    int ey;
    int eaddr;
    bit edone;
  } vec_t;

  function automatic logic [DW-1:0] exp_pix(input int k);
    int px = k % W;
    int py = k / W;
    if (TP) return DW'((px + 16 * py) % (1 << DW));
    return mem[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel k of the frame is presented once per completed handshake, frames wrap after N.
  task automatic monitor();
    if (rd1) begin
      chk("rnd_rd_addr", 32'(addr1), idx);
      chk("rnd_single_rd", 32'(rd_since), 0);
      chk("rnd_rd_in_gap", 32'(in_gap), 0);
      rd_since = 1'b1;
    end
    if (end1 && !prev_end) begin
      chk("rnd_pixel", 32'(pix1), 32'(exp_pix(idx)));
      chk("rnd_x", 32'(x1), idx % W);
      chk("rnd_y", 32'(y1), idx / W);
    end
    if (prev_end && !end1) begin
      chk("rnd_done", 32'(done1), 32'(idx == N - 1));
      rd_since = 1'b0;
      if (idx == N - 1) begin
        idx = 0; in_gap = 1'b1; gap_hi = 1'b0;
      end else begin
        idx++;
      end
    end else if (done1) begin
      chk("rnd_spurious_done", 32'(done1), 0);
    end
    if (in_gap) begin
      if (end_frame) gap_hi = 1'b1;
      else if (gap_hi) in_gap = 1'b0;
    end
    prev_end = end1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (addr1 > AW'(N - 1)) addr_over = 1'b1;
    if (rd1) rd_total++;
    if (mon_en) monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1; ready = 1'b0; end_frame = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic do_hs(output bit ok, output int px, output int ox, output int oy,
                       output int rds, output int raddr, output int dones);
    int n = 0;
    ready = 1'b1; rds = 0; raddr = -1; dones = 0;
    do begin
      tick();
      if (rd1) begin rds++; raddr = int'(addr1); end
      n++;
    end while (!end1 && n < 40);
    ok = end1; px = int'(pix1); ox = int'(x1); oy = int'(y1);
    ready = 1'b0;
    repeat (2) begin
      tick();
      if (done1) dones++;
      if (rd1) rds++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[N];
    bit   ok;
    int   px, ox, oy, rds, raddr, dones, gr, ge, n;

    for (int k = 0; k < N; k++) tbl[k] = '{k % W, k / W, k, k == N - 1};

    // Reset state and first-pixel latency
    repeat (3) tick();
    chk("reset_ctrl", 32'({end1, busy1, rd1, done1}), 0);
    chk("reset_addr", 32'(addr1), 0);
    chk("reset_xy", 32'({x1, y1}), 0);
    chk("reset_pixel", 32'(pix1), 0);
    mem[0] = 12'hABC;
    reset = 1'b0; ready = 1'b1;
    for (int c = 1; c <= LAT1; c++) begin
      tick();
      if (c == 1) begin
        chk("first_rd", 32'(rd1), 32'(RD_EXP));
        chk("first_addr", 32'(addr1), 0);
      end
      chk("first_end_latency", 32'(end1), 32'(c == LAT1));
    end
    chk("first_pixel", 32'(pix1), 32'(exp_pix(0)));
    chk("first_xy", 32'({x1, y1}), 0);
    repeat (5) begin
      tick();
      chk("hold_end", 32'(end1), 1);
      chk("hold_pixel", 32'(pix1), 32'(exp_pix(0)));
      chk("hold_xy", 32'({x1, y1}), 0);
      chk("hold_no_rd", 32'(rd1), 0);
    end
    ready = 1'b0;
    tick();
    chk("release_end", 32'(end1), 0);
    tick();
    chk("advance_addr", 32'(addr1), 1);
    chk("advance_x", 32'(x1), 1);

    // Full frame, table driven, memory data = address
    do_reset();
    for (int a = 0; a < 16; a++) mem[a] = DW'(a);
    for (int k = 0; k < N; k++) begin
      do_hs(ok, px, ox, oy, rds, raddr, dones);
      chk("frame_present", 32'(ok), 1);
      chk("frame_pixel", px, 32'(exp_pix(tbl[k].eaddr)));
      chk("frame_x", ox, tbl[k].ex);
      chk("frame_y", oy, tbl[k].ey);
      chk("frame_rd_count", rds, 32'(RD_EXP));
`ifndef PIXEL_FEEDER_TEST_PATTERN_EN
      chk("frame_rd_addr", raddr, tbl[k].eaddr);
`endif
      chk("frame_done", dones, 32'(tbl[k].edone));
    end

    // Frame gap ignores requests until end_frame pulses
    ready = 1'b1; gr = 0; ge = 0;
    repeat (6) begin
      tick();
      gr += int'(rd1);
      ge += int'(end1);
    end
    chk("gap_no_rd", gr, 0);
    chk("gap_no_end", ge, 0);
    chk("gap_busy", 32'(busy1), 1);
    end_frame = 1'b1;
    repeat (3) tick();
    end_frame = 1'b0;
    do_hs(ok, px, ox, oy, rds, raddr, dones);
    chk("gap_exit_present", 32'(ok), 1);
    chk("gap_exit_xy", 32'({ox[11:0], oy[11:0]}), 0);
    chk("gap_exit_pixel", px, 32'(exp_pix(0)));
    chk("gap_exit_rd_count", rds, 32'(RD_EXP));
`ifndef PIXEL_FEEDER_TEST_PATTERN_EN
    chk("gap_exit_rd_addr", raddr, 0);
`endif

    // Long memory latency, then reset while presenting
    do_reset();
    mem[0] = 12'h5A5;
    ready = 1'b1;
    for (int c = 1; c <= LAT3; c++) begin
      tick();
      if (c == 1) chk("lat3_rd", 32'(rd3), 32'(RD_EXP));
      chk("lat3_end_latency", 32'(end3), 32'(c == LAT3));
    end
    chk("lat3_pixel", 32'(pix3), 32'(exp_pix(0)));
    chk("pre_reset_present", 32'(end1), 1);
    reset = 1'b1;
    tick();
    chk("midreset_ctrl", 32'({end1, busy1, rd1, done1, pix1, x1}), 0);
    chk("midreset_y_addr", 32'({y1, addr1}), 0);
    reset = 1'b0;
    tick();
    chk("postreset_rd", 32'(rd1), 32'(RD_EXP));
    chk("postreset_addr", 32'(addr1), 0);

    // Randomized detector against the reference model
    do_reset();
    for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
    idx = 0; prev_end = 1'b0; rd_since = 1'b0; in_gap = 1'b0; gap_hi = 1'b0;
    mon_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (in_gap) begin
        if (!end_frame) begin
          ready = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) tick();
          end_frame = 1'b1;
        end
        repeat ($urandom_range(2, 4)) tick();
        end_frame = 1'b0; ready = 1'b0;
        tick();
      end
      ready = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
      if ($urandom_range(0, 4) == 0) begin
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      ready = 1'b1; n = 0;
      while (!end1 && n < 40) begin
        tick();
        n++;
      end
      chk("rnd_present_timeout", 32'(end1), 1);
      repeat ($urandom_range(0, 3)) tick();
      if (idx == N - 1 && $urandom_range(0, 1) == 1) end_frame = 1'b1;
      ready = 1'b0;
      tick();
    end
    mon_en = 1'b0;
    chk("addr_in_range", 32'(addr_over), 0);
`ifdef PIXEL_FEEDER_TEST_PATTERN_EN
    chk("tp_no_mem_rd", rd_total, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
